// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard transmitter: queues scan-code bytes in a small FIFO
// and serialises each one as an 11-bit frame (start, 8 data LSB first, odd parity, stop).
module ps2_keyboard_tx #(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    frames_sent
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  state_t           state_reg;
  logic [CNT_W-1:0] div_reg;
  logic [3:0]       bit_idx_reg;
  // Bits still to send after the start bit: {stop, parity, data}, LSB next.
  logic [9:0]       frame_reg;
  logic             push;
  logic             pop;

  assign in_ready   = (count_reg != FIFO_FULL);
  assign push       = in_valid && in_ready;
  assign pop        = (state_reg == IDLE) && (count_reg != '0);
  assign busy       = (count_reg != '0) || (state_reg != IDLE);
  assign fifo_count = count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      state_reg   <= IDLE;
      div_reg     <= '0;
      bit_idx_reg <= '0;
      frame_reg   <= '1;
      ps2_clk     <= 1'b1;
      ps2_data    <= 1'b1;
      frames_sent <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase

      case (state_reg)
        IDLE: begin
          ps2_clk <= 1'b1;
          if (pop) begin
            frame_reg   <= {1'b1, ~^fifo_mem[rd_ptr_reg], fifo_mem[rd_ptr_reg]};
            ps2_data    <= 1'b0;
            bit_idx_reg <= '0;
            div_reg     <= '0;
            state_reg   <= HIGH;
          end else begin
            ps2_data <= 1'b1;
          end
        end
        HIGH: begin
          if (div_reg == DIV_LAST) begin
            ps2_clk   <= 1'b0;
            div_reg   <= '0;
            state_reg <= LOW;
          end else begin
            div_reg <= div_reg + CNT_W'(1);
          end
        end
        LOW: begin
          // Data only moves on the rising edge, keeping it stable around each fall.
          if (div_reg == DIV_LAST) begin
            ps2_clk <= 1'b1;
            div_reg <= '0;
            if (bit_idx_reg == 4'd10) begin
              frames_sent <= frames_sent + 8'd1;
              state_reg   <= GAP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 4'd1;
              ps2_data    <= frame_reg[0];
              frame_reg   <= {1'b1, frame_reg[9:1]};
              state_reg   <= HIGH;
            end
          end else begin
            div_reg <= div_reg + CNT_W'(1);
          end
        end
        GAP: begin
          if (div_reg == GAP_LAST) begin
            div_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            div_reg <= div_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Directed bench for ps2_keyboard_tx: frame contents, timing, FIFO backpressure,
// reset truncation, and a 256-frame loopback through a synchronising receiver.
module tb_ps2_keyboard_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst;
  logic       a_valid, a_ready, a_pclk, a_pdata, a_busy;
  logic [7:0] a_data, a_sent;
  logic [3:0] a_count;
  logic       b_valid, b_ready, b_pclk, b_pdata, b_busy;
  logic [7:0] b_data, b_sent;
  logic [3:0] b_count;

  ps2_keyboard_tx #(.CLK_DIV(4), .GAP_CYCLES(32), .FIFO_DEPTH(8)) u_dut_a (
    .clk(clk), .reset(srst), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
    .ps2_clk(a_pclk), .ps2_data(a_pdata), .busy(a_busy), .fifo_count(a_count),
    .frames_sent(a_sent)
  );

  ps2_keyboard_tx #(.CLK_DIV(8), .GAP_CYCLES(4), .FIFO_DEPTH(8)) u_dut_b (
    .clk(clk), .reset(srst), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
    .ps2_clk(b_pclk), .ps2_data(b_pdata), .busy(b_busy), .fifo_count(b_count),
    .frames_sent(b_sent)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on instance A: direct falling-edge sampling, frame timing and idle gaps.
  int          mon_bits   = 0;
  int          fall_total = 0;
  int          high_run   = 0;
  logic        prev_pclk  = 1'b1;
  logic [10:0] mon_acc    = '0;
  logic [10:0] frame_q[$];
  int          first_fall_q[$];
  int          gap_q[$];

  always @(negedge clk) begin
    if (prev_pclk && !a_pclk) begin
      fall_total <= fall_total + 1;
      if (mon_bits == 0) first_fall_q.push_back(cyc);
      mon_acc[mon_bits] <= a_pdata;
      if (mon_bits == 10) begin
        frame_q.push_back({a_pdata, mon_acc[9:0]});
        mon_bits <= 0;
      end else begin
        mon_bits <= mon_bits + 1;
      end
    end else if (mon_bits == 0) begin
      if (a_pclk && a_pdata) begin
        high_run <= high_run + 1;
      end else if (high_run > 0) begin
        gap_q.push_back(high_run);
        high_run <= 0;
      end
    end
    if (!a_busy) mon_bits <= 0;
    prev_pclk <= a_pclk;
  end

  // Receiver on instance B: 3-stage synchroniser, samples data on the synced fall.
  logic [2:0]  rx_csync = '1;
  logic [2:0]  rx_dsync = '1;
  logic [10:0] rx_acc   = '0;
  int          rx_bits  = 0;
  logic [10:0] rx_q[$];

  always @(posedge clk) begin
    rx_csync <= {rx_csync[1:0], b_pclk};
    rx_dsync <= {rx_dsync[1:0], b_pdata};
    if (srst) begin
      rx_bits <= 0;
    end else if (rx_csync[2] && !rx_csync[1]) begin
      rx_acc[rx_bits] <= rx_dsync[1];
      if (rx_bits == 10) begin
        rx_q.push_back({rx_dsync[1], rx_acc[9:0]});
        rx_bits <= 0;
      end else begin
        rx_bits <= rx_bits + 1;
      end
    end
  end

  typedef struct {
    string       name;
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s: %0d (0x%0h)", name, act, act);
    end
  endtask

  function automatic bit frame_ok(input logic [10:0] f);
    int ones = 0;
    for (int i = 1; i <= 9; i++) ones += int'(f[i]);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (ones % 2 == 1);
  endfunction

  task automatic push_byte(input logic [7:0] b, output int edge_n);
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = b;
    edge_n  = cyc + 1;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int limit);
    int k = 0;
    while (frame_q.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (frame_q.size() < n) begin
      total++;
      bad++;
      $display("FAIL wait_frames: got %0d frames expected %0d", frame_q.size(), n);
    end
  endtask

  initial begin
    int pe;
    int exp_sent;
    int next;
    int k;
    int falls_before;
    bit acc;
    bit timeout;

    vecs[0] = '{"byte_1C", 8'h1C, 11'h438};
    vecs[1] = '{"byte_F0", 8'hF0, 11'h7E0};
    vecs[2] = '{"byte_00", 8'h00, 11'h600};
    vecs[3] = '{"byte_FF", 8'hFF, 11'h7FE};

    srst = 1'b1;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ps2_clk", int'(a_pclk), 1);
    check("rst_ps2_data", int'(a_pdata), 1);
    check("rst_fifo_count", int'(a_count), 0);
    check("rst_in_ready", int'(a_ready), 1);
    check("rst_busy", int'(a_busy), 0);
    check("rst_frames_sent", int'(a_sent), 0);
    srst = 1'b0;
    repeat (2) @(negedge clk);

    // Single 0x1C: bit sequence, first-fall latency, completion.
    frame_q.delete(); first_fall_q.delete();
    push_byte(8'h1C, pe);
    wait_frames(1, 400);
    if (frame_q.size() >= 1) begin
      check("t1_frame_1C", int'(frame_q[0]), 'h438);
      check("t1_first_fall_latency", first_fall_q[0] - pe, 5);
    end
    repeat (40) @(negedge clk);
    check("t1_frames_sent", int'(a_sent), 1);
    check("t1_busy_after_gap", int'(a_busy), 0);
    exp_sent = 1;

    // Table of single-byte frames, including the 0x00 / 0xFF parity corners.
    for (int i = 0; i < 4; i++) begin
      frame_q.delete();
      push_byte(vecs[i].data, pe);
      wait_frames(1, 400);
      if (frame_q.size() >= 1) check({"tbl_", vecs[i].name}, int'(frame_q[0]), int'(vecs[i].frame));
      repeat (40) @(negedge clk);
      exp_sent++;
      check({"tbl_sent_", vecs[i].name}, int'(a_sent), exp_sent);
    end

    // Make/break sequence queued on consecutive cycles.
    frame_q.delete(); first_fall_q.delete(); gap_q.delete();
    @(negedge clk); a_valid = 1'b1; a_data = 8'h1C;
    @(negedge clk); a_data = 8'hF0;
    @(negedge clk); a_data = 8'h1C;
    @(negedge clk); a_valid = 1'b0;
    wait_frames(3, 600);
    if (frame_q.size() >= 3) begin
      check("t2_frame0", int'(frame_q[0]), 'h438);
      check("t2_frame1", int'(frame_q[1]), 'h7E0);
      check("t2_frame2", int'(frame_q[2]), 'h438);
      check("t2_F0_parity", int'(frame_q[1][9]), 1);
      check("t2_spacing01", first_fall_q[1] - first_fall_q[0], 121);
      check("t2_spacing12", first_fall_q[2] - first_fall_q[1], 121);
    end
    if (gap_q.size() >= 3) begin
      check("t2_gap1", gap_q[1], 33);
      check("t2_gap2", gap_q[2], 33);
    end
    repeat (40) @(negedge clk);
    exp_sent += 3;
    check("t2_frames_sent", int'(a_sent), exp_sent);

    // Hold in_valid with incrementing bytes until the FIFO backs up.
    frame_q.delete();
    next = 1;
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = 8'(next);
    for (int j = 0; j < 2000 && next <= 9; j++) begin
      acc = a_ready;
      @(negedge clk);
      if (acc) begin
        next++;
        a_data = 8'(next);
      end
    end
    a_valid = 1'b0;
    check("t4_count_full", int'(a_count), 8);
    check("t4_ready_full", int'(a_ready), 0);
    k = 0;
    while (a_count == 4'd8 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("t4_count_after_pop", int'(a_count), 7);
    check("t4_ready_after_pop", int'(a_ready), 1);
    wait_frames(9, 9 * 121 + 300);
    repeat (40) @(negedge clk);
    check("t4_frame_total", frame_q.size(), 9);
    for (int j = 0; j < frame_q.size() && j < 9; j++) begin
      check($sformatf("t4_data%0d", j), int'(frame_q[j][8:1]), j + 1);
      check($sformatf("t4_ok%0d", j), int'(frame_ok(frame_q[j])), 1);
    end
    exp_sent += 9;
    check("t4_frames_sent", int'(a_sent), exp_sent);

    // Reset in the middle of a frame with two more bytes still queued.
    frame_q.delete();
    @(negedge clk); a_valid = 1'b1; a_data = 8'h1C;
    @(negedge clk); a_data = 8'hF0;
    @(negedge clk); a_data = 8'h1C;
    @(negedge clk); a_valid = 1'b0;
    k = 0;
    while (mon_bits != 5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t5_reached_fall5", mon_bits, 5);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    check("t5_ps2_clk", int'(a_pclk), 1);
    check("t5_ps2_data", int'(a_pdata), 1);
    check("t5_fifo_count", int'(a_count), 0);
    check("t5_busy", int'(a_busy), 0);
    check("t5_frames_sent", int'(a_sent), 0);
    check("t5_in_ready", int'(a_ready), 1);
    falls_before = fall_total;
    repeat (300) @(negedge clk);
    check("t5_no_edges", fall_total - falls_before, 0);
    check("t5_no_frames", frame_q.size(), 0);
    push_byte(8'h1C, pe);
    wait_frames(1, 400);
    if (frame_q.size() >= 1) check("t5_recover_frame", int'(frame_q[0]), 'h438);
    repeat (40) @(negedge clk);
    check("t5_recover_sent", int'(a_sent), 1);

    // Loopback of 256 bytes into the synchronising receiver, CLK_DIV=8.
    rx_q.delete();
    timeout = 1'b0;
    for (int i = 0; i < 256 && !timeout; i++) begin
      b_valid = 1'b1;
      b_data  = 8'(i);
      acc = 1'b0;
      for (int w = 0; w < 1000 && !acc; w++) begin
        acc = b_ready;
        @(negedge clk);
      end
      if (!acc) timeout = 1'b1;
    end
    b_valid = 1'b0;
    check("t6_push_timeout", int'(timeout), 0);
    k = 0;
    while (rx_q.size() < 255 && k < 60000) begin
      @(negedge clk);
      k++;
    end
    check("t6_rx_255", rx_q.size(), 255);
    repeat (12) @(negedge clk);
    check("t6_sent_255", int'(b_sent), 255);
    k = 0;
    while (rx_q.size() < 256 && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (12) @(negedge clk);
    check("t6_sent_wrap", int'(b_sent), 0);
    check("t6_rx_256", rx_q.size(), 256);
    for (int i = 0; i < rx_q.size() && i < 256; i++) begin
      check($sformatf("t6_rx_data%0d", i), int'(rx_q[i][8:1]), i);
      check($sformatf("t6_rx_ok%0d", i), int'(frame_ok(rx_q[i])), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_tx.md
Name: ps2_keyboard_tx

Overview:
Device-side PS/2 keyboard transmitter. It serialises scan-code bytes into standard 11-bit PS/2 frames on ps2_clk/ps2_data. Frames are start 0, 8 data bits LSB first, odd parity, stop 1. It acts as the keyboard model that drives the board's PS/2 receiver in simulation and loopback tests. A small input FIFO lets a stimulus source queue make/break sequences (e.g. 1C, F0, 1C) without waiting on the slow serial link.

Parameters:
CLK_DIV, 8, system clocks per ps2_clk half-period (high or low phase); must be >= 4.
GAP_CYCLES, 32, idle clocks (ps2_clk=1, ps2_data=1) inserted after every frame.
FIFO_DEPTH, 8, input FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  byte offered to FIFO
in_data  input  8  scan-code byte
in_ready  output  1  FIFO can accept; equals !full
ps2_clk  output  1  PS/2 clock to receiver; idle 1
ps2_data  output  1  PS/2 data to receiver; idle 1
busy  output  1  1 when the FIFO is non-empty or state != IDLE
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
frames_sent  output  8  completed-frame counter; wraps 255->0

Behaviour:
- Reset (synchronous, wins over everything): ps2_clk=1, ps2_data=1, FIFO flushed (fifo_count=0, in_ready=1), busy=0, frames_sent=0, state=IDLE, div/bit counters 0.
  - A frame in flight is truncated immediately; no completion or stop bit is emitted.
- FIFO: push on in_valid && in_ready. in_ready is computed from occupancy before the current edge, so no push occurs while full even if a pop happens in the same cycle. Pop occurs only on the IDLE->HIGH transition. A simultaneous push and pop leaves fifo_count unchanged. Data order is strictly FIFO.
- Frame shift register, 11 bits, LSB sent first: {1'b1, ~^data, data[7:0], 1'b0}. Parity is odd over data+parity.
- States:
  - IDLE: ps2_clk=1, ps2_data=1. If the FIFO is non-empty: pop, load shift register, ps2_data<=0 (start), bit_idx<=0, div<=0, go to HIGH.
  - HIGH: ps2_clk=1, ps2_data holds the current bit. div counts 0..CLK_DIV-1. At CLK_DIV-1: ps2_clk<=0, div<=0, go to LOW. This is the falling edge where the receiver samples.
  - LOW: ps2_clk=0. At div==CLK_DIV-1: ps2_clk<=1, div<=0.
    - If bit_idx==10: frames_sent++, ps2_data stays 1, go to GAP.
    - Otherwise: bit_idx++, ps2_data<=next bit, go to HIGH.
  - GAP: lines idle-high for GAP_CYCLES clocks, then go to IDLE.
- Data changes only on the same edge that raises ps2_clk. Data is therefore stable for CLK_DIV clocks before each falling edge and CLK_DIV clocks after it.
- Latency:
  - Byte accepted at edge t → loaded at edge t+1 (if idle).
  - First falling edge at t+1+CLK_DIV.
  - Frame duration is 22*CLK_DIV clocks from load to GAP entry, giving exactly 11 falling edges.
  - Back-to-back frame spacing is 22*CLK_DIV + GAP_CYCLES + 1 clocks.
- in_valid while busy is fine: bytes queue in the FIFO. in_data is ignored when in_valid=0.
- frames_sent increments once per completed frame and wraps modulo 256.

Test Plan:
1. CLK_DIV=4; push 0x1C when idle.
   - Required: ps2_data sampled at the 11 ps2_clk falling edges = 0,0,0,1,1,1,0,0,0,0,1.
   - Required: first fall 5 clocks after the push edge; frames_sent=1; busy=0 after GAP.
2. Push 0x1C, 0xF0, 0x1C on consecutive cycles.
   - Required: three frames in order; F0 parity bit = 1.
   - Required: inter-frame idle-high gap is exactly GAP_CYCLES+1 clocks; frames_sent=3.
3. Push 0x00 and 0xFF.
   - Required: parity bits 1 and 1 respectively; stop bit = 1 on both.
4. Hold in_valid with incrementing bytes 0x01.. while the first frame runs.
   - Required: in_ready drops when fifo_count=FIFO_DEPTH.
   - Required: bytes transmitted 0x01..0x09 (depth 8 plus 1 in flight) with no loss or duplication.
   - Required: in_ready rises in the cycle after each pop.
5. Queue 3 bytes, then assert reset for 1 cycle after the 5th falling edge of frame 1.
   - Required next cycle: ps2_clk=1, ps2_data=1, fifo_count=0, busy=0, frames_sent=0.
   - Required: no further edges until a new push.
6. Loopback into the board PS/2 receiver (3-stage clk sync, falling-edge sampling) with CLK_DIV=8.
   - Required: every received byte equals the sent byte, with the receiver's parity/start/stop checks passing.
   - Required: frames_sent wraps to 0 after 256 frames.
